flux_tag_merger: RTL
====================

Name: flux_tag_merger

Overview:
Write-side front end for the tagged multi-flow pick FIFO. It collects words from FLUX independent producer streams and buffers each stream locally. It then arbitrates round-robin, places the flow index in the tag field (MSBs), and drives the FIFO's single wr/datain port, honouring the FIFO's full flag. This makes it the writer counterpart to the FIFO's per-flow read/empty interface. One merger sits in front of each pick FIFO instance.

Parameters:
WIDTH, 8, total FIFO word width including tag; must equal the FIFO's WIDTH.
FLUX, 2, number of producer flows; FLUX >= 2.
TAG_WIDTH, $clog2(FLUX), derived; tag bits, datain[WIDTH-1 -: TAG_WIDTH].
PAY_WIDTH, WIDTH-TAG_WIDTH, derived; payload bits per flow.
SKID_DEPTH, 2, per-flow local buffer entries; power of two >= 2.

Ports:
ck  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low (rst==0 resets).
in_valid  in  FLUX  per-flow producer valid.
in_data  in  FLUX*PAY_WIDTH  per-flow payload; flow f occupies bits [f*PAY_WIDTH +: PAY_WIDTH].
in_ready  out  FLUX  per-flow accept; the transfer happens when in_valid[f] & in_ready[f] at the edge.
full  in  1  FIFO full flag (combinational from the FIFO).
wr  out  1  FIFO write strobe.
datain  out  WIDTH  FIFO write word, {tag, payload}.
pending  out  FLUX  per-flow "local buffer non-empty".

Behaviour:
- Reset (rst==0, asynchronous):
  - All skid buffers empty; pointers and counters = 0.
  - Output stage invalid; datain = 0.
  - Round-robin pointer last_grant = FLUX-1, so flow 0 has first priority.
  - Outputs during reset: wr = 0, in_ready = all 1, pending = 0.
  - Reset asserted mid-operation discards all buffered words. wr drops in the same cycle, no edge required.
- Per-flow skid buffer:
  - Circular, SKID_DEPTH entries, count width $clog2(SKID_DEPTH)+1.
  - in_ready[f] = (count[f] < SKID_DEPTH), registered-state only; no combinational path from full or in_valid.
  - Push and pop of the same flow in one edge: count unchanged; pointers wrap modulo SKID_DEPTH.
  - pending[f] = (count[f] != 0).
- Output stage: one register holding out_vld and datain.
  - wr = out_vld & full==0, combinational. This is the only combinational path: full -> wr.
  - The FIFO captures datain at the edge where wr==1; the stage is drained at that same edge.
- Arbiter:
  - Evaluated every cycle. load_ok = (out_vld==0) | (wr==1).
  - If load_ok and any pending: grant the first flow f with pending[f]==1, scanning last_grant+1, last_grant+2, ... modulo FLUX.
  - At the edge: pop flow f, datain <= {f[TAG_WIDTH-1:0], head payload}, out_vld <= 1, last_grant <= f.
  - If load_ok and nothing pending: out_vld <= 0 at the edge.
  - If load_ok==0: hold, with datain stable while out_vld==1 & full==1.
- Latency and throughput:
  - A word accepted at edge N into an empty buffer, with no contention and full==0, gives wr==1 in the cycle after edge N+1.
  - Sustained throughput is 1 word/cycle aggregate while full==0.
- Fairness: with all flows continuously pending, grants rotate 0,1,...,FLUX-1,0,...; no flow waits more than FLUX-1 grants.
- Full:
  - wr is never 1 while full==1. The word is held, and no FIFO overflow occurs.
  - Producers back up into skids; in_ready[f] drops when count[f]==SKID_DEPTH.
- Ordering: per-flow order is preserved exactly. Cross-flow order is defined only by the arbiter.
- Tag values >= FLUX are never generated.

Test Plan:
1. Reset then single word:
   - Stimulus: rst low 3 cycles, release; flow 1 sends payload 0x2A at edge 5; full=0; WIDTH=8, FLUX=2.
   - Required: wr=1 with datain=0xAA (tag 1, payload 0x2A) in the cycle after edge 6; wr=0 otherwise.
2. Round-robin fairness:
   - Stimulus: FLUX=4, all flows hold valid with incrementing payloads, full=0.
   - Required: tags on consecutive wr cycles are 0,1,2,3,0,1,... and each flow's payloads appear in order.
3. Backpressure:
   - Stimulus: full=1 for 10 cycles while flow 0 streams.
   - Required: wr=0 throughout and datain stable; in_ready[0]=0 after 3 words accepted (2 skid + 1 output stage).
   - On full=0: wr=1 the same cycle, and those 3 words drain in order on consecutive cycles.
4. Simultaneous push/pop:
   - Stimulus: flow 0 with count=1; push and grant at the same edge.
   - Required: count stays 1, no word lost or duplicated, and the scoreboard matches.
5. Reset mid-burst:
   - Stimulus: rst=0 while out_vld=1 and skids hold words.
   - Required: wr=0 immediately; after release, no stale word is ever written; in_ready all 1.
6. Random soak:
   - Stimulus: 10k cycles, random valid/full, checked against the FIFO model.
   - Required: zero writes while full==1, per-flow order preserved, and every accepted word written exactly once.

Source files
------------

// File: rtl/flux_tag_merger.sv
// Write-side front end for the tagged multi-flow pick FIFO: per-flow skid buffers,
// round-robin arbitration, tag insertion and a single full-aware output stage.
module flux_tag_merger #(
    parameter int WIDTH      = 8,
    parameter int FLUX       = 2,
    parameter int SKID_DEPTH = 2,
    localparam int TAG_WIDTH = $clog2(FLUX),
    localparam int PAY_WIDTH = WIDTH - TAG_WIDTH
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic [FLUX-1:0]           in_valid,
    input  logic [FLUX*PAY_WIDTH-1:0] in_data,
    output logic [FLUX-1:0]           in_ready,
    input  logic                      full,
    output logic                      wr,
    output logic [WIDTH-1:0]          datain,
    output logic [FLUX-1:0]           pending
);

    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PAY_WIDTH-1:0] mem_q [FLUX][SKID_DEPTH];
    logic [PAY_WIDTH-1:0] mem_d [FLUX][SKID_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [FLUX];
    logic [PTR_W-1:0]     wr_ptr_d [FLUX];
    logic [PTR_W-1:0]     rd_ptr_q [FLUX];
    logic [PTR_W-1:0]     rd_ptr_d [FLUX];
    logic [CNT_W-1:0]     cnt_q [FLUX];
    logic [CNT_W-1:0]     cnt_d [FLUX];

    logic                 out_vld_q, out_vld_d;
    logic [WIDTH-1:0]     datain_q, datain_d;
    logic [TAG_WIDTH-1:0] last_grant_q, last_grant_d;

    logic [FLUX-1:0]      push, pop;
    logic                 load_ok;
    logic                 grant_vld;
    logic [TAG_WIDTH-1:0] grant_idx;

    // Skid status is derived from registered counts only, so in_ready never depends on full.
    always_comb begin
        in_ready = '0;
        pending  = '0;
        for (int f = 0; f < FLUX; f++) begin
            in_ready[f] = (cnt_q[f] < CNT_W'(SKID_DEPTH));
            pending[f]  = (cnt_q[f] != '0);
        end
    end

    assign wr      = out_vld_q & ~full;
    assign datain  = datain_q;
    assign load_ok = ~out_vld_q | wr;

    // Round-robin scan starting just after the most recently granted flow.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= FLUX; k++) begin
            idx = (int'(last_grant_q) + k) % FLUX;
            if (!grant_vld && pending[idx]) begin
                grant_vld = 1'b1;
                grant_idx = TAG_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        out_vld_d    = out_vld_q;
        datain_d     = datain_q;
        last_grant_d = last_grant_q;
        push         = '0;
        pop          = '0;

        for (int f = 0; f < FLUX; f++) begin
            push[f] = in_valid[f] & in_ready[f];
            pop[f]  = load_ok & grant_vld & (grant_idx == TAG_WIDTH'(f));
            if (push[f]) begin
                mem_d[f][wr_ptr_q[f]] = in_data[f*PAY_WIDTH +: PAY_WIDTH];
                wr_ptr_d[f]           = wr_ptr_q[f] + PTR_W'(1);
            end
            if (pop[f]) begin
                rd_ptr_d[f] = rd_ptr_q[f] + PTR_W'(1);
            end
            cnt_d[f] = cnt_q[f] + CNT_W'(push[f]) - CNT_W'(pop[f]);
        end

        // The stage reloads whenever it is empty or being written this edge.
        if (load_ok) begin
            if (grant_vld) begin
                out_vld_d    = 1'b1;
                datain_d     = {grant_idx, mem_q[grant_idx][rd_ptr_q[grant_idx]]};
                last_grant_d = grant_idx;
            end else begin
                out_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int f = 0; f < FLUX; f++) begin
                for (int e = 0; e < SKID_DEPTH; e++) begin
                    mem_q[f][e] <= '0;
                end
                wr_ptr_q[f] <= '0;
                rd_ptr_q[f] <= '0;
                cnt_q[f]    <= '0;
            end
            out_vld_q    <= 1'b0;
            datain_q     <= '0;
            last_grant_q <= TAG_WIDTH'(FLUX - 1);
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            out_vld_q    <= out_vld_d;
            datain_q     <= datain_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
